// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer: IDLE -> FETCH -> EXEC with
// branch/jump/trap redirects, deferred trap redirects during a fetch, and alignment checks.
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] generated_immediate,
    input  logic            branch_decision,
    input  logic            pc_add_write_value,
    input  logic [XLEN-1:0] pc_write_value,
    input  logic            auipc_in,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_add_out,
    output logic            misaligned
);

    localparam int unsigned     INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] ALIGN_MASK  = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] seq_c, branch_tgt_c, jump_tgt_c, redirect_tgt_c;

    assign seq_c        = pc_q + XLEN'(INSTR_BYTES);
    assign branch_tgt_c = pc_q + (generated_immediate << 1);
    assign jump_tgt_c   = pc_write_value + generated_immediate;
    assign pc_add_out   = auipc_in ? jump_tgt_c : seq_c;

    // Jump outranks branch; the selected target is the one alignment-checked.
    assign redirect_tgt_c = pc_add_write_value ? jump_tgt_c : branch_tgt_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            pending_q    <= 1'b0;
            pend_tgt_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pend_tgt_q   <= pend_tgt_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        pend_tgt_d   = pend_tgt_q;
        misaligned_d = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // A trap on the ack edge counts as pending and wins over the older target.
                if (imem_ack) begin
                    if (trap_valid || pending_q) begin
                        pc_d      = trap_valid ? trap_vector : pend_tgt_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d = EXEC;
                    end
                end else if (trap_valid) begin
                    pending_d  = 1'b1;
                    pend_tgt_d = trap_vector;
                end
            end
            EXEC: begin
                if (trap_valid) begin
                    pc_d    = trap_vector;
                    state_d = FETCH;
                end else if (!stall) begin
                    state_d = FETCH;
                    if (pc_add_write_value || branch_decision) begin
                        if ((redirect_tgt_c & ALIGN_MASK) != '0) begin
                            pc_d         = trap_vector;
                            misaligned_d = 1'b1;
                        end else begin
                            pc_d = redirect_tgt_c;
                        end
                    end else begin
                        pc_d = seq_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign misaligned  = misaligned_q;

endmodule
